reward_weight_update: RTL
=========================

# reward_weight_update

Reward-modulated plasticity stage that sits directly downstream of the multilayer inference core in the SNN. After each inference it takes the winning output index, the input spike trace and an external reward/punish flag. It then read-modify-writes the weights of the winning output row in the shared weight memory, potentiating or depressing each weight whose presynaptic input fired. Its read/write ports are arbitrated into the same weight memory the inference core uses.

## Interface
Parameters:
- `ADDR_W`, 4, weight memory address width; address = {out_idx[1:0], in_idx[1:0]}
- `DW`, 8, weight width; weights are unsigned
- `ETA`, 4, learning step added or subtracted per update (must be < 2^DW)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  **synchronous, active-low reset**
- `start`  in  1  one-cycle request to run an update; sampled only in IDLE
- `pred`  in  2  winning output index from inference
- `pre_spikes`  in  4  bit i = input i fired during the inference window
- `reward`  in  2  2'b01 potentiate; 2'b10 depress; 2'b00/2'b11 no update
- `rd_req`  out  1  read request, one cycle per weight
- `rd_addr`  out  ADDR_W  read address, valid while `rd_req`=1
- `rd_valid`  in  1  read data valid (≥1 cycle after `rd_req`)
- `rd_data`  in  DW  read data
- `wr_en`  out  1  write strobe, one cycle per weight
- `wr_addr`  out  ADDR_W  write address
- `wr_data`  out  DW  updated weight
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of update
- `upd_count`  out  3  number of writes issued in the last update (0–4); held until next `start`

## Operation
- FSM states: IDLE, SCAN, READ, WAIT, WRITE, DONE. Outputs are decoded from registered state/data only; there is no combinational input-to-output path.
- IDLE: on `start`=1, latch `pred`, `pre_spikes` and `reward`, clear `idx` and `upd_count`.
  - If reward is 01 or 10 → SCAN.
  - Otherwise → DONE, with `upd_count`=0.
- SCAN: if `spikes_q[idx]`=1 → READ. Else if `idx`=3 → DONE. Else `idx`++ and stay in SCAN.
- READ: `rd_req`=1, `rd_addr`={pred_q, idx} for exactly one cycle → WAIT.
- WAIT: `rd_req`=0. Hold in WAIT until `rd_valid`=1, then register the new value into `wr_data` → WRITE.
- WRITE: `wr_en`=1, `wr_addr`={pred_q, idx}, `upd_count`++. Then → DONE if `idx`=3, else `idx`++ → SCAN.
- DONE: `done`=1 for one cycle → IDLE.
- Arithmetic is unsigned and saturating, computed at DW+1 bits:
  - potentiate: `min(old+ETA, 2^DW−1)`
  - depress: `old<ETA ? 0 : old−ETA`
- `start` while `busy`=1 is ignored.
- `rd_valid` outside WAIT is ignored.
- `pred`, `pre_spikes` and `reward` changing after the `start` cycle have no effect.
- Reset (`rst_n`=0 at a clock edge), including mid-update:
  - state → IDLE, `idx`=0.
  - All outputs are 0: `rd_req`, `rd_addr`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`, `upd_count`.
  - Any outstanding read is abandoned; a late `rd_valid` is ignored.

## Timing
- Per fired input, with `rd_valid` one cycle after `rd_req`: SCAN, READ, WAIT, WRITE = 4 cycles.
- Per skipped input: 1 SCAN cycle.
- Let `start` be sampled at edge T:
  - all 4 spikes: READ at T+2, WRITEs at T+4/8/12/16, `done` at T+17
  - no spikes: `done` at T+5
  - reward 00/11: `done` at T+1
- Each added cycle of read latency extends WAIT by one cycle.
- `busy` rises at T+1 and falls in the cycle after `done`.
- A new `start` is accepted in the cycle after `done` at the earliest.
- `wr_en` never coincides with `rd_req`.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles → all outputs 0, state IDLE. Assert reset in WAIT, then pulse `rd_valid` → no `wr_en`, `done` never fires.
- Potentiate: `pred`=2, `pre_spikes`=4'b1111, `reward`=01, memory row 2 = {10,20,30,40}, 1-cycle read latency → writes to addr 8,9,10,11 of {14,24,34,44}; `done` at T+17; `upd_count`=4.
- Depress with sparse spikes and saturation: `pred`=1, `pre_spikes`=4'b0101, `reward`=10, weights at addr 4=3, 6=100 → writes addr 4=0, addr 6=96 only; `upd_count`=2.
- Upper saturation: `reward`=01, `pre_spikes`=4'b1000, `pred`=3, weight at addr 15=253 → write addr 15=255.
- No-op paths:
  - `reward`=00 → `done` at T+1, no `rd_req`.
  - `pre_spikes`=0 with `reward`=01 → `done` at T+5, `upd_count`=0.
- Stall/robustness: `rd_valid` delayed by 5 cycles → `rd_req` asserted exactly once, WAIT holds. A `start` pulse during `busy` → ignored. A spurious `rd_valid` in SCAN → ignored.

Source files
------------

// File: rtl/reward_weight_update.sv
// Reward-modulated plasticity: read-modify-writes the winning output row of the shared
// weight memory, potentiating or depressing each weight whose presynaptic input fired.
module reward_weight_update #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned ETA    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        pred,
  input  logic [3:0]        pre_spikes,
  input  logic [1:0]        reward,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DW-1:0]     rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        upd_count
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StScan  = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [DW-1:0] EtaN = DW'(ETA);

  logic [2:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    pred_q, pred_d;
  logic [3:0]    spikes_q, spikes_d;
  logic          pot_q, pot_d;
  logic [2:0]    upd_q, upd_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [DW:0]   sum_w;
  logic [DW-1:0] new_w;

  // Saturating update; the carry bit of the widened sum flags overflow.
  always_comb begin
    sum_w = {1'b0, rd_data} + {1'b0, EtaN};
    if (pot_q) begin
      new_w = sum_w[DW] ? '1 : sum_w[DW-1:0];
    end else begin
      new_w = (rd_data < EtaN) ? '0 : (rd_data - EtaN);
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pred_d   = pred_q;
    spikes_d = spikes_q;
    pot_d    = pot_q;
    upd_d    = upd_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pred_d   = pred;
          spikes_d = pre_spikes;
          pot_d    = (reward == 2'b01);
          idx_d    = '0;
          upd_d    = '0;
          state_d  = (reward == 2'b01 || reward == 2'b10) ? StScan : StDone;
        end
      end
      StScan: begin
        if (spikes_q[idx_q]) begin
          state_d = StRead;
        end else if (idx_q == 2'd3) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        if (rd_valid) begin
          wdata_d = new_w;
          state_d = StWrite;
        end
      end
      StWrite: begin
        upd_d = upd_q + 3'd1;
        if (idx_q == 2'd3) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StScan;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      pred_q   <= '0;
      spikes_q <= '0;
      pot_q    <= 1'b0;
      upd_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pred_q   <= pred_d;
      spikes_q <= spikes_d;
      pot_q    <= pot_d;
      upd_q    <= upd_d;
      wdata_q  <= wdata_d;
    end
  end

  // All outputs come straight from registers; no input reaches an output combinationally.
  always_comb begin
    rd_req    = (state_q == StRead);
    wr_en     = (state_q == StWrite);
    done      = (state_q == StDone);
    busy      = (state_q != StIdle);
    rd_addr   = ADDR_W'({pred_q, idx_q});
    wr_addr   = ADDR_W'({pred_q, idx_q});
    wr_data   = wdata_q;
    upd_count = upd_q;
  end

endmodule
